// File: rtl/sopc_be_mem_arb_pkg.sv
// Shared types and constants for the on-chip RAM arbiter.
package sopc_be_mem_arb_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sopc_be_rr_arbiter.sv
// Rotating-priority one-hot grant: first requester at or after i_ptr, wrapping.
module sopc_be_rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic w_found;

  // First pass covers indices >= ptr; the second pass wraps to the lowest index.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_req[j] && (PTR_W'(j) >= i_ptr)) begin
        o_gnt[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_req[j]) begin
        o_gnt[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sopc_be_onchip_memory_arbiter.sv
// Round-robin arbiter with bounded hold sharing one 1-cycle-latency RAM between NUM_REQ requesters.
// Grant is combinational; reads return one cycle later on a shared bus tagged by readdatavalid.
module sopc_be_onchip_memory_arbiter
  import sopc_be_mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MEM_DEPTH = 10000,
  parameter int MAX_HOLD  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ*BE_W-1:0]     req_byteenable,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_readdatavalid,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [BE_W-1:0]             mem_byteenable,
  output logic                        mem_chipselect,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_writedata,
  output logic                        mem_clken,
  input  logic [DATA_W-1:0]           mem_readdata,
  output logic                        oor_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_ptr;
  logic [3:0]         r_hold;
  logic               r_pend_vld;
  logic [PTR_W-1:0]   r_pend_id;
  logic               r_pend_oor;
  logic               r_oor_err;
  logic [ADDR_W-1:0]  r_addr_last;

  cmd_t               w_cmd_arr [NUM_REQ];
  cmd_t               w_cmd;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic [NUM_REQ-1:0] w_rr_req;
  logic [NUM_REQ-1:0] w_rr_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_others;
  logic               w_keep;
  logic               w_vld;
  logic               w_inrange;
  logic               w_rd_acc;
  logic               w_err;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd
    assign w_req[g]     = req_read[g] | req_write[g];
    assign w_cmd_arr[g] = '{addr:  req_address[g*ADDR_W +: ADDR_W],
                            be:    req_byteenable[g*BE_W +: BE_W],
                            rd:    req_read[g],
                            wr:    req_write[g],
                            wdata: req_writedata[g*DATA_W +: DATA_W]};
  end

  always_comb begin
    w_owner_oh = '0;
    for (int j = 0; j < NUM_REQ; j++) w_owner_oh[j] = (PTR_W'(j) == r_owner);
  end

  assign w_others = |(w_req & ~w_owner_oh);
  assign w_keep   = (r_state == OWNED) && |(w_req & w_owner_oh) &&
                    (!w_others || (r_hold < 4'(MAX_HOLD)));
  assign w_rr_req = (r_state == OWNED) ? (w_req & ~w_owner_oh) : w_req;

  // While OWNED the pointer already sits at owner+1, so one arbiter serves both states.
  sopc_be_rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .i_req (w_rr_req),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt)
  );

  assign w_gnt = reset ? '0 : (w_keep ? w_owner_oh : w_rr_gnt);
  assign w_vld = |w_gnt;

  always_comb begin
    w_cmd     = '0;
    w_gnt_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_gnt[j]) begin
        w_cmd     = w_cmd_arr[j];
        w_gnt_idx = PTR_W'(j);
      end
    end
  end

  assign w_inrange = (int'(w_cmd.addr) < MEM_DEPTH);
  assign w_rd_acc  = w_vld & w_cmd.rd & ~w_cmd.wr;
  assign w_err     = w_vld & (~w_inrange | (w_cmd.rd & w_cmd.wr));

  assign req_waitrequest = ~w_gnt;
  assign mem_chipselect  = w_vld & w_inrange;
  assign mem_write       = mem_chipselect & w_cmd.wr;
  assign mem_address     = w_vld ? w_cmd.addr : r_addr_last;
  assign mem_byteenable  = w_cmd.be;
  assign mem_writedata   = w_cmd.wdata;
  assign mem_clken       = 1'b1;
  assign req_readdata    = r_pend_oor ? '0 : mem_readdata;
  assign oor_err         = r_oor_err;

  always_comb begin
    req_readdatavalid = '0;
    for (int j = 0; j < NUM_REQ; j++)
      req_readdatavalid[j] = r_pend_vld & ~reset & (r_pend_id == PTR_W'(j));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_hold  <= '0;
      r_ptr   <= '0;
    end else if (w_vld) begin
      r_state <= OWNED;
      if ((r_state == OWNED) && (w_gnt_idx == r_owner)) begin
        if (r_hold < 4'(MAX_HOLD)) r_hold <= r_hold + 4'd1;
      end else begin
        r_owner <= w_gnt_idx;
        r_hold  <= 4'd1;
        r_ptr   <= PTR_W'(wrap_inc(int'(w_gnt_idx), NUM_REQ));
      end
    end else if (r_state == OWNED) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_vld  <= 1'b0;
      r_pend_id   <= '0;
      r_pend_oor  <= 1'b0;
      r_oor_err   <= 1'b0;
      r_addr_last <= '0;
    end else begin
      r_pend_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_pend_id  <= w_gnt_idx;
        r_pend_oor <= ~w_inrange;
      end
      if (w_err) r_oor_err <= 1'b1;
      if (w_vld) r_addr_last <= w_cmd.addr;
    end
  end

endmodule

// File: tb/tb_sopc_be_onchip_memory_arbiter.sv
// Directed + random bench: 2-requester instance with a RAM model and read scoreboard, 4-requester fairness instance.
module tb_sopc_be_onchip_memory_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- 2-requester instance ----------------
  logic        rst2;
  logic [13:0] a2u  [2];
  logic [3:0]  be2u [2];
  logic [31:0] wd2u [2];
  logic [1:0]  rd2, wr2;
  logic [27:0] a2;
  logic [7:0]  be2;
  logic [63:0] wd2;
  logic [1:0]  wait2, rdv2;
  logic [31:0] rdata2, mwd2, mrd2;
  logic [13:0] maddr2;
  logic [3:0]  mbe2;
  logic        mcs2, mwr2, mclk2, oor2;

  assign a2  = {a2u[1], a2u[0]};
  assign be2 = {be2u[1], be2u[0]};
  assign wd2 = {wd2u[1], wd2u[0]};

  sopc_be_onchip_memory_arbiter #(.NUM_REQ(2), .MEM_DEPTH(10000), .MAX_HOLD(4)) dut2 (
    .clk(clk), .reset(rst2),
    .req_address(a2), .req_byteenable(be2), .req_read(rd2), .req_write(wr2),
    .req_writedata(wd2), .req_waitrequest(wait2), .req_readdata(rdata2),
    .req_readdatavalid(rdv2), .mem_address(maddr2), .mem_byteenable(mbe2),
    .mem_chipselect(mcs2), .mem_write(mwr2), .mem_writedata(mwd2),
    .mem_clken(mclk2), .mem_readdata(mrd2), .oor_err(oor2)
  );

  logic [31:0] ram    [0:16383];
  logic [31:0] shadow [0:16383];

  always @(posedge clk) begin
    if (mcs2) begin
      if (mwr2) ram[maddr2] <= (ram[maddr2] & ~be_mask(mbe2)) | (mwd2 & be_mask(mbe2));
      mrd2 <= ram[maddr2];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rdv2 != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_rdv", 32'(rdv2), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rdv_id", 32'(rdv2), 32'd1 << e.id);
        chk("rdata", rdata2, e.data);
      end
    end
  end

  task automatic xfer2(input bit i, input bit rd, input bit wr, input logic [13:0] addr,
                       input logic [3:0] be, input logic [31:0] d);
    bit   ok = 1'b0;
    exp_t e;
    rd2[i] = rd; wr2[i] = wr; a2u[i] = addr; be2u[i] = be; wd2u[i] = d;
    for (int n = 0; n < 16 && !ok; n++) begin
      @(negedge clk);
      if (!wait2[i]) ok = 1'b1;
      else tick();
    end
    chk("accept", 32'(ok), 32'd1);
    if (ok) begin
      if (rd && !wr) begin
        e.id   = int'(i);
        e.data = (int'(addr) < 10000) ? shadow[addr] : 32'h0;
        sb.push_back(e);
      end
      if (wr && int'(addr) < 10000)
        shadow[addr] = (shadow[addr] & ~be_mask(be)) | (d & be_mask(be));
      tick();
      rd2[i] = 1'b0; wr2[i] = 1'b0;
    end
  endtask

  task automatic pulse2();
    rst2 = 1'b1;
    tick(); tick();
    rst2 = 1'b0;
  endtask

  // ---------------- 4-requester instance ----------------
  logic         rst4;
  logic [55:0]  a4;
  logic [15:0]  be4;
  logic [3:0]   rd4, wr4, wait4, rdv4;
  logic [127:0] wd4;
  logic [31:0]  rdata4, mwd4;
  logic [31:0]  mrd4 = 32'h0;
  logic [13:0]  maddr4;
  logic [3:0]   mbe4;
  logic         mcs4, mwr4, mclk4, oor4;

  sopc_be_onchip_memory_arbiter #(.NUM_REQ(4), .MEM_DEPTH(10000), .MAX_HOLD(1)) dut4 (
    .clk(clk), .reset(rst4),
    .req_address(a4), .req_byteenable(be4), .req_read(rd4), .req_write(wr4),
    .req_writedata(wd4), .req_waitrequest(wait4), .req_readdata(rdata4),
    .req_readdatavalid(rdv4), .mem_address(maddr4), .mem_byteenable(mbe4),
    .mem_chipselect(mcs4), .mem_write(mwr4), .mem_writedata(mwd4),
    .mem_clken(mclk4), .mem_readdata(mrd4), .oor_err(oor4)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  g2;
    logic [1:0]  cont_exp [9];
    logic [3:0]  g4;
    logic [3:0]  gnt_prev;
    int          wcnt [4];

    rst2 = 1'b1; rst4 = 1'b1;
    rd2 = '0; wr2 = '0;
    for (int i = 0; i < 2; i++) begin a2u[i] = '0; be2u[i] = '0; wd2u[i] = '0; end
    rd4 = '0; wr4 = '0; a4 = '0; be4 = '1; wd4 = '0;
    tick(); tick();

    // Reset state
    @(negedge clk);
    chk("rst_wait", 32'(wait2), 32'h3);
    chk("rst_rdv", 32'(rdv2), 32'h0);
    chk("rst_cs", 32'(mcs2), 32'h0);
    chk("rst_mwr", 32'(mwr2), 32'h0);
    chk("rst_oor", 32'(oor2), 32'h0);
    chk("clken", 32'(mclk2), 32'h1);
    tick();
    rst2 = 1'b0;

    // Preload RAM through the arbiter
    xfer2(1'b0, 1'b0, 1'b1, 14'h0010, 4'hF, 32'hDEADBEEF);
    xfer2(1'b0, 1'b0, 1'b1, 14'h2000, 4'hF, 32'hAABBCCDD);
    xfer2(1'b0, 1'b0, 1'b1, 14'd9999, 4'hF, 32'h12345678);

    // Single read: accepted in cycle 0, data in cycle 1
    pulse2();
    rd2[0] = 1'b1; a2u[0] = 14'h0010;
    @(negedge clk);
    chk("single_wait", 32'(wait2), 32'h2);
    chk("single_cs", 32'(mcs2), 32'h1);
    chk("single_addr", 32'(maddr2), 32'h10);
    sb.push_back('{id: 0, data: 32'hDEADBEEF});
    tick();
    rd2[0] = 1'b0;
    @(negedge clk);
    chk("single_rdv", 32'(rdv2), 32'h1);
    chk("idle_addr_hold", 32'(maddr2), 32'h10);
    chk("idle_cs", 32'(mcs2), 32'h0);
    tick();

    // Contention, MAX_HOLD=4
    pulse2();
    cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    a2u[0] = 14'h0101; a2u[1] = 14'h0201; be2u[0] = 4'hF; be2u[1] = 4'hF;
    wd2u[0] = 32'h0; wd2u[1] = 32'h1;
    wr2 = 2'b11;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      g2 = ~wait2;
      chk("contention_gnt", 32'(g2), 32'(cont_exp[k]));
      tick();
    end
    wr2 = 2'b00;
    tick();

    // Byte write from R1, then back-to-back reads
    xfer2(1'b1, 1'b0, 1'b1, 14'h2000, 4'h3, 32'h11223344);
    xfer2(1'b1, 1'b1, 1'b0, 14'h2000, 4'hF, 32'h0);
    xfer2(1'b1, 1'b1, 1'b0, 14'h0010, 4'hF, 32'h0);
    @(negedge clk);
    chk("bytewrite_shadow", shadow[14'h2000], 32'hAABB3344);
    tick();

    // Range boundaries
    xfer2(1'b0, 1'b1, 1'b0, 14'd9999, 4'hF, 32'h0);
    @(negedge clk);
    chk("oor_9999", 32'(oor2), 32'h0);
    tick();
    wr2[0] = 1'b1; a2u[0] = 14'd10000; wd2u[0] = 32'hCAFEF00D;
    @(negedge clk);
    chk("oor_wr_accept", 32'(wait2[0]), 32'h0);
    chk("oor_wr_cs", 32'(mcs2), 32'h0);
    chk("oor_wr_mwr", 32'(mwr2), 32'h0);
    tick();
    wr2[0] = 1'b0;
    @(negedge clk);
    chk("oor_set", 32'(oor2), 32'h1);
    tick();
    xfer2(1'b0, 1'b1, 1'b0, 14'd16383, 4'hF, 32'h0);
    @(negedge clk);
    chk("oor_sticky", 32'(oor2), 32'h1);
    tick(); tick();

    // Reset while a read is pending
    rd2[1] = 1'b1; a2u[1] = 14'h0010;
    @(negedge clk);
    chk("midrst_accept", 32'(wait2[1]), 32'h0);
    tick();
    rd2[1] = 1'b0; rst2 = 1'b1;
    @(negedge clk);
    chk("midrst_wait", 32'(wait2), 32'h3);
    chk("midrst_rdv0", 32'(rdv2), 32'h0);
    tick();
    @(negedge clk);
    chk("midrst_rdv1", 32'(rdv2), 32'h0);
    chk("midrst_oor", 32'(oor2), 32'h0);
    tick();
    rst2 = 1'b0;
    @(negedge clk);
    chk("midrst_rdv2", 32'(rdv2), 32'h0);
    tick();

    // Read and write together: write wins, read dropped, error flagged
    rd2[0] = 1'b1; wr2[0] = 1'b1; a2u[0] = 14'h0300; be2u[0] = 4'hF; wd2u[0] = 32'h55;
    @(negedge clk);
    chk("rdwr_mwr", 32'(mwr2), 32'h1);
    tick();
    rd2[0] = 1'b0; wr2[0] = 1'b0;
    shadow[14'h0300] = 32'h55;
    @(negedge clk);
    chk("rdwr_oor", 32'(oor2), 32'h1);
    chk("rdwr_no_rdv", 32'(rdv2), 32'h0);
    tick();
    xfer2(1'b0, 1'b1, 1'b0, 14'h0300, 4'hF, 32'h0);
    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    // Four requesters, MAX_HOLD=1: strict rotation
    rst4 = 1'b0;
    wr4 = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g4 = ~wait4;
      chk("rotation_gnt", 32'(g4), 32'd1 << (k % 4));
      tick();
    end
    wr4 = 4'h0;
    tick();

    // Random requests, each held until granted; wait must stay within 3 cycles
    gnt_prev = 4'h0;
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!wr4[i] || gnt_prev[i]) begin
          wr4[i] = ($urandom_range(0, 3) != 0);
          a4[i*14 +: 14] = 14'($urandom_range(0, 9999));
        end
      end
      @(negedge clk);
      gnt_prev = ~wait4;
      chk("rand_onehot", 32'($onehot0(gnt_prev)), 32'h1);
      chk("rand_gnt_req", 32'(gnt_prev & ~wr4), 32'h0);
      chk("rand_work_conserving", 32'(gnt_prev != 4'h0), 32'(wr4 != 4'h0));
      for (int i = 0; i < 4; i++) begin
        if (wr4[i] && !gnt_prev[i]) wcnt[i]++;
        else wcnt[i] = 0;
        chk("rand_wait_bound", 32'(wcnt[i] <= 3), 32'h1);
      end
      tick();
    end
    wr4 = 4'h0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
